// File: rtl/stream_fifo_if.sv
// Valid/ready stream bundle around stream_fifo: upstream beat, downstream head and occupancy status.
// master modport is the producer/consumer environment; slave modport is the FIFO itself.
// Parameters must match the stream_fifo instance the bundle is connected to.
interface stream_fifo_if #(
   parameter int DWIDTH = 8,
   parameter int DEPTH  = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic              in_valid;
   logic [DWIDTH-1:0] in_data;
   logic              in_ready;
   logic              out_valid;
   logic [DWIDTH-1:0] out_data;
   logic              out_ready;
   logic [CW-1:0]     count;
   logic              full;
   logic              empty;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, count, full, empty
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, count, full, empty
   );
endinterface

// File: rtl/stream_fifo.sv
// Elastic valid/ready FIFO behind the arbiter output; in_ready = ~full, never a function of out_ready.
// Latency 1 cycle from storage; with STREAM_FIFO_BYPASS_EN defined an empty FIFO forwards a beat in 0 cycles.
// Backpressure: when full no push occurs, even if a pop happens in the same cycle.
module stream_fifo #(
   parameter int DWIDTH = 8,
   parameter int DEPTH  = 4
) (
   input logic          clk,
   input logic          rst,
   stream_fifo_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [DWIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]     wr_idx, rd_idx;
   logic              empty, full;
   logic              push, pop;
   logic [DWIDTH-1:0] head_dat;

   // Status purely from the registered pointer pair; the MSB is the wrap bit
   always_comb begin
      wr_idx   = wr_ptr_q[AW-1:0];
      rd_idx   = rd_ptr_q[AW-1:0];
      empty    = (wr_ptr_q == rd_ptr_q);
      full     = (wr_idx == rd_idx) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
      head_dat = mem_q[rd_idx];
   end

   // Handshake and output datapath; bypass only changes behaviour while empty
   always_comb begin
      bus.in_ready = ~full;
      bus.count    = wr_ptr_q - rd_ptr_q;
      bus.full     = full;
      bus.empty    = empty;
`ifdef STREAM_FIFO_BYPASS_EN
      bus.out_valid = ~empty | bus.in_valid;
      if (!empty) begin
         bus.out_data = head_dat;
      end else if (bus.in_valid) begin
         bus.out_data = bus.in_data;
      end else begin
         bus.out_data = '0;
      end
      pop  = ~empty & bus.out_ready;
      // A beat forwarded straight through while empty never touches storage
      push = bus.in_valid & ~full & ~(empty & bus.out_ready);
`else
      bus.out_valid = ~empty;
      bus.out_data  = empty ? '0 : head_dat;
      pop           = ~empty & bus.out_ready;
      push          = bus.in_valid & ~full;
`endif
   end

   // Next pointer values: each advances by one per transfer and wraps naturally
   always_comb begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
   end

   // Pointer registers with synchronous active-low reset that empties the FIFO
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage array is not reset; a beat offered during the reset cycle is dropped
   always_ff @(posedge clk) begin
      if (push && rst) begin
         mem_q[wr_idx] <= bus.in_data;
      end
   end

   // Upstream must hold a stalled beat offered with unchanged payload until accepted
   a_in_hold: assert property (@(posedge clk) disable iff (!rst)
      (bus.in_valid && !bus.in_ready) |=> (bus.in_valid && $stable(bus.in_data)));
endmodule

// File: doc/stream_fifo.md
Name: stream_fifo

Overview:
- Parameterised synchronous valid/ready FIFO placed directly downstream of the fixed-priority arbiter output.
- Absorbs arbiter grants while the consumer stalls, so the arbiter's `out_ready` no longer depends combinationally on the far-end consumer.
- Removes that combinational `ready` path and gives the arbitration stage elastic buffering.
- Same handshake semantics as the arbiter: a beat transfers when valid and ready are both high on a rising clock edge.

Parameters:
- DWIDTH, 8, payload width in bits.
- DEPTH, 4, number of storage entries; power of two, minimum 2.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  synchronous reset, active-low (asserted when 0, sampled on rising clk).
- in_valid  input  1  upstream (arbiter out_valid) beat present.
- in_data  input  DWIDTH  upstream payload.
- in_ready  output  1  FIFO accepts a beat this cycle.
- out_valid  output  1  head beat available.
- out_data  output  DWIDTH  head payload; all-zero when out_valid=0.
- out_ready  input  1  downstream accepts head beat.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- full  output  1  count==DEPTH.
- empty  output  1  count==0.

Behaviour:
- Storage: DEPTH x DWIDTH register array, not reset.
- Write pointer and read pointer each have width $clog2(DEPTH)+1; the MSB is the wrap bit.
  - empty when the pointers are equal.
  - full when the low bits are equal and the MSBs differ.
- count = wr_ptr - rd_ptr, modulo 2^($clog2(DEPTH)+1); registered-pointer derived, no extra counter state required.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = ~full.
  - Depends only on registered state; no combinational path from out_ready to in_ready.
  - When full, no push occurs even if a pop happens in the same cycle.
- out_valid = ~empty; out_data = mem[rd_ptr low bits] when ~empty, else 0 (first-word-fall-through from storage).
- Latency: a beat pushed at edge N is visible on out_valid/out_data after edge N (cycle N+1); minimum latency 1 cycle.
- Simultaneous push and pop: both pointers advance, count unchanged.
  - Legal at any non-full occupancy, including count==1 (the head is popped and the new beat becomes the head).
- Pointer wrap: pointers increment by 1 and wrap naturally at 2^($clog2(DEPTH)+1); ordering is preserved across wrap.
- Stall: with out_valid=1 and out_ready=0, out_data holds its value.
- Rules upstream must meet (assertion-checked in simulation):
  - in_data stable while in_valid=1 and in_ready=0.
  - in_valid not withdrawn before acceptance.
- Reset (rst=0 at a rising edge): wr_ptr=rd_ptr=0, giving count=0, empty=1, full=0, in_ready=1, out_valid=0, out_data=0.
  - Reset mid-operation discards all stored beats; any beat presented in the reset cycle is not stored.
- No state machine beyond the pointer pair; behaviour is fully defined by push/pop per cycle.

Optional Feature:
- Macro: STREAM_FIFO_BYPASS_EN.
- Defined: when empty=1 and in_valid=1, the FIFO forwards the input in the same cycle, with 0-cycle latency:
  - out_valid=1 and out_data=in_data.
  - If out_ready=1 the beat transfers directly and is not written to storage; pointers are unchanged.
  - If out_ready=0 the beat is pushed normally (in_ready=1) and becomes the head next cycle.
- With bypass, out_valid and out_data depend combinationally on in_valid and in_data; in_ready is still ~full.
- Not defined: strictly registered output path; out_valid=0 whenever empty regardless of in_valid; latency 1.

Test Plan:
- Reset then idle: hold rst=0 for 2 cycles, release. Expect count=0, empty=1, full=0, in_ready=1, out_valid=0, out_data=0x00.
- Fill and stall: DEPTH=4, out_ready=0, push 0x11, 0x22, 0x33, 0x44, 0x55 on consecutive cycles.
  - Expect count 1..4 and full=1 after the 4th push; in_ready=0; 0x55 not accepted.
  - Expect out_data=0x11 held stable throughout.
- Drain order and wrap: continue from the full state, out_ready=1.
  - Expect pops 0x11, 0x22, 0x33, 0x44 in order, then empty=1.
  - Push 6 more beats 0xA0..0xA5 with random out_ready; expect in-order delivery across pointer wrap.
- Simultaneous push/pop: at count=2, hold in_valid=1 and out_ready=1 for 5 cycles with data 0xB0..0xB4. Expect count stays 2 and 5 beats popped in order.
- Mid-operation reset: at count=3, assert rst=0 for 1 cycle while in_valid=1 with data 0xCC. Expect next cycle count=0, out_valid=0, and 0xCC never emitted.
- Bypass (STREAM_FIFO_BYPASS_EN defined): empty, in_valid=1, in_data=0x5A, out_ready=1.
  - Expect out_valid=1, out_data=0x5A the same cycle, and count remains 0.
  - Without the macro: expect out_valid=0 that cycle, then 0x5A on the next cycle.
